// File: rtl/bpf_defs_pkg.sv
// Shared definitions for the packet read path: BPF load size codes,
// the read-adapter state encoding and a size-to-byte-count helper.
package bpf_defs;

  // BPF load size codes as carried on req_sz; code 3 behaves as a byte load.
  localparam logic [1:0] BPF_W = 2'd0;
  localparam logic [1:0] BPF_H = 2'd1;
  localparam logic [1:0] BPF_B = 2'd2;

  // Read-adapter FSM states, kept as plain constants for older tool flows.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD1  = 2'd1;
  localparam logic [1:0] RD2  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Number of bytes fetched by a load of the given size code.
  function automatic logic [2:0] bpf_bytes(input logic [1:0] sz);
    case (sz)
      BPF_W:   return 3'd4;
      BPF_H:   return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/packet_read_adapter_read_lane_select.sv
// read_lane_select: picks 1, 2 or 4 bytes starting at a byte offset out of
// two consecutive big-endian memory words and right-aligns them in a
// zero-padded 32-bit result. Purely combinational.
module read_lane_select
  import bpf_defs::*;
#(
  parameter  int MEM_BYTES_LOG2 = 2,
  localparam int MEM_DATA_WIDTH = 8 * (2 ** MEM_BYTES_LOG2)
) (
  input  logic [MEM_DATA_WIDTH-1:0] word_hi_i,  // word holding the start byte
  input  logic [MEM_DATA_WIDTH-1:0] word_lo_i,  // following word, used when spanning
  input  logic [MEM_BYTES_LOG2-1:0] offset_i,
  input  logic [1:0]                size_i,
  output logic [31:0]               data_o
);

  localparam int NB = 2 ** MEM_BYTES_LOG2;

  logic [2*MEM_DATA_WIDTH-1:0] pair;
  logic [2:0]                  nbytes;

  assign pair   = {word_hi_i, word_lo_i};
  assign nbytes = bpf_bytes(size_i);

  // Shift selected bytes in, lowest address first, so it ends most significant.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns a default first so no latch is inferred.
    data_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(nbytes)) begin
        data_o = {data_o[23:0], pair[(2*NB-1-(int'(offset_i)+k))*8 +: 8]};
      end
    end
  end

endmodule

// File: rtl/packet_read_adapter.sv
// packet_read_adapter: turns byte-addressed 1/2/4-byte BPF loads into one or
// two reads of a word-wide, one-cycle-latency packet memory (big-endian) and
// returns the zero-padded value over a valid/ready response port.
// Optional feature: define PACKET_READ_ADAPTER_BOUNDS_CHECK_EN to add the
// pkt_len input and rsp_err output; loads past pkt_len then skip memory and
// answer immediately with rsp_data=0, rsp_err=1.
module packet_read_adapter
  import bpf_defs::*;
#(
  parameter  int BYTE_ADDR_WIDTH = 12,
  parameter  int MEM_BYTES_LOG2  = 2,
  localparam int MEM_DATA_WIDTH  = 8 * (2 ** MEM_BYTES_LOG2),
  localparam int WORD_ADDR_WIDTH = BYTE_ADDR_WIDTH - MEM_BYTES_LOG2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]                 req_sz,
  output logic                       mem_rd_en,
  output logic [WORD_ADDR_WIDTH-1:0] mem_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [31:0]                rsp_data
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
  ,
  input  logic [BYTE_ADDR_WIDTH:0]   pkt_len,
  output logic                       rsp_err
`endif
);

  localparam int NB = 2 ** MEM_BYTES_LOG2;

  logic [1:0]                 state_q, state_d;
  logic [MEM_BYTES_LOG2-1:0]  off_q, off_d;
  logic [1:0]                 sz_q, sz_d;
  logic [WORD_ADDR_WIDTH-1:0] word_q, word_d;
  logic [MEM_DATA_WIDTH-1:0]  hold_q, hold_d;
  logic [31:0]                rsp_data_q, rsp_data_d;
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
  logic                       err_q, err_d;
`endif

  logic                       req_fire;
  logic                       oob;
  logic                       spanning;
  logic [MEM_DATA_WIDTH-1:0]  lane_hi;
  logic [31:0]                lane_data;

  // Gating with rst_n keeps the read strobe low while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign req_fire  = req_ready && req_valid;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;

`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
  assign oob     = ({1'b0, req_addr} + (BYTE_ADDR_WIDTH+1)'(bpf_bytes(req_sz))) > pkt_len;
  assign rsp_err = err_q;
`else
  assign oob     = 1'b0;
`endif

  // A load spans two words when its last byte falls past the end of the first.
  assign spanning = (int'(off_q) + int'(bpf_bytes(sz_q))) > NB;

  // In RD2 the first word comes from the capture register, otherwise straight from memory.
  assign lane_hi = (state_q == RD2) ? hold_q : mem_rdata;

  read_lane_select #(
    .MEM_BYTES_LOG2(MEM_BYTES_LOG2)
  ) u_lane (
    .word_hi_i(lane_hi),
    .word_lo_i(mem_rdata),
    .offset_i (off_q),
    .size_i   (sz_q),
    .data_o   (lane_data)
  );

  // Next-state, memory strobe and response data for each FSM state.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    sz_d       = sz_q;
    word_d     = word_q;
    hold_d     = hold_q;
    rsp_data_d = rsp_data_q;
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
    err_d      = err_q;
`endif
    mem_rd_en  = 1'b0;
    mem_addr   = word_q + WORD_ADDR_WIDTH'(1);
    case (state_q)
      IDLE: begin
        mem_addr = req_addr[BYTE_ADDR_WIDTH-1:MEM_BYTES_LOG2];
        if (req_fire) begin
          off_d  = req_addr[MEM_BYTES_LOG2-1:0];
          sz_d   = req_sz;
          word_d = req_addr[BYTE_ADDR_WIDTH-1:MEM_BYTES_LOG2];
          if (oob) begin
            rsp_data_d = '0;
            state_d    = RESP;
          end else begin
            mem_rd_en = 1'b1;
            state_d   = RD1;
          end
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
          err_d = oob;
`endif
        end
      end
      RD1: begin
        if (spanning) begin
          hold_d    = mem_rdata;
          mem_rd_en = 1'b1;
          state_d   = RD2;
        end else begin
          rsp_data_d = lane_data;
          state_d    = RESP;
        end
      end
      RD2: begin
        rsp_data_d = lane_data;
        state_d    = RESP;
      end
      default: begin
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= '0;
      sz_q       <= BPF_W;
      word_q     <= '0;
      hold_q     <= '0;
      rsp_data_q <= '0;
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
      state_q    <= state_d;
      off_q      <= off_d;
      sz_q       <= sz_d;
      word_q     <= word_d;
      hold_q     <= hold_d;
      rsp_data_q <= rsp_data_d;
`ifdef PACKET_READ_ADAPTER_BOUNDS_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule
